// File: rtl/store_pkg.sv
// Shared encodings for the store merge unit: FSM states, store sizes and
// the request decode helpers used when a store is accepted.
package store_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  // Byte wins over Half, so a request with both set is a byte store.
  function automatic logic [1:0] decode_size(input logic byte_sel, input logic half_sel);
    if (byte_sel)      return SZ_BYTE;
    else if (half_sel) return SZ_HALF;
    else               return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian read-modify-write merge: overlays the new byte or halfword
// onto the old RAM word; a word store replaces the whole word.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    merged_o[7:0]   = new_data_i[7:0];
          2'd1:    merged_o[15:8]  = new_data_i[7:0];
          2'd2:    merged_o[23:16] = new_data_i[7:0];
          default: merged_o[31:24] = new_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane_i[1]) merged_o[31:16] = new_data_i[15:0];
        else           merged_o[15:0]  = new_data_i[15:0];
      end
      default: merged_o = new_data_i;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store unit for a word-wide synchronous data RAM: sw writes directly,
// sb/sh do a read-modify-write, misaligned stores are rejected without a write.
module store_merge_unit
  import store_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        Memwrite,
  input  logic        Byte,
  input  logic        Half,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  input  logic [31:0] Mem_rdata,
  output logic [9:0]  Mem_addr,
  output logic        Mem_we,
  output logic [31:0] Mem_wdata,
  output logic        Stall,
  output logic        Done,
  output logic        Misalign
);

  logic [1:0]  state_q, state_d;
  logic [11:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q,  size_d;

  logic [1:0]  req_size;
  logic        accept;
  logic        unused_addr_hi;

  assign req_size       = decode_size(Byte, Half);
  assign accept         = (state_q == ST_IDLE) && Memwrite;
  assign unused_addr_hi = ^Addr[31:12];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE: begin
        if (Memwrite) begin
          addr_d  = Addr[11:0];
          wdata_d = Wdata;
          size_d  = req_size;
          if (is_misaligned(req_size, Addr[1:0])) state_d = ST_ERR;
          else if (req_size == SZ_WORD)           state_d = ST_WRITE;
          else                                    state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_WRITE;
      // WRITE and ERR last one cycle; the CPU advances on that edge, so IDLE
      // only ever sees the next instruction.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_WORD;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
    end
  end

  // Status outputs are forced low while reset is held, even mid-store.
  assign Stall    = !rst && (accept || (state_q == ST_READ));
  assign Mem_we   = !rst && (state_q == ST_WRITE);
  assign Done     = !rst && ((state_q == ST_WRITE) || (state_q == ST_ERR));
  assign Misalign = !rst && (state_q == ST_ERR);
  assign Mem_addr = (state_q == ST_IDLE) ? Addr[11:2] : addr_q[11:2];

  byte_lane_merge u_merge (
    .old_word_i (Mem_rdata),
    .new_data_i (wdata_q),
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .merged_o   (Mem_wdata)
  );

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit: directed stores push expected RAM
// writes and completions; an independent monitor checks them as they appear.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Memwrite, Byte, Half;
  logic [31:0] Addr, Wdata, Mem_rdata;
  logic [9:0]  Mem_addr;
  logic        Mem_we;
  logic [31:0] Mem_wdata;
  logic        Stall, Done, Misalign;

  always #5 clk = ~clk;

  store_merge_unit dut (
    .clk       (clk),
    .rst       (rst),
    .Memwrite  (Memwrite),
    .Byte      (Byte),
    .Half      (Half),
    .Addr      (Addr),
    .Wdata     (Wdata),
    .Mem_rdata (Mem_rdata),
    .Mem_addr  (Mem_addr),
    .Mem_we    (Mem_we),
    .Mem_wdata (Mem_wdata),
    .Stall     (Stall),
    .Done      (Done),
    .Misalign  (Misalign)
  );

  // Synchronous RAM model with a side port for preloading words.
  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    Mem_rdata <= mem[Mem_addr];
    if (Mem_we === 1'b1) mem[Mem_addr] <= Mem_wdata;
    else if (pre_we)     mem[pre_idx]  <= pre_val;
  end

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  wr_q[$];
  logic done_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, after the driver has settled its inputs.
  always @(negedge clk) begin
    wr_t  w;
    logic m;
    #2;
    if (Mem_we === 1'b1) begin
      if (wr_q.size() == 0) check("unexpected_we", {31'b0, Mem_we}, 32'd0);
      else begin
        w = wr_q.pop_front();
        check("we_addr", {22'b0, Mem_addr}, {22'b0, w.addr});
        check("we_data", Mem_wdata, w.data);
      end
    end
    if (Done === 1'b1) begin
      if (done_q.size() == 0) check("unexpected_done", {31'b0, Done}, 32'd0);
      else begin
        m = done_q.pop_front();
        check("done_misalign", {31'b0, Misalign}, {31'b0, m});
      end
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  task automatic go_idle();
    Memwrite = 1'b0;
    Byte     = 1'b0;
    Half     = 1'b0;
    @(negedge clk);
  endtask

  // Holds Memwrite until Done, counting stall cycles and the Done cycle.
  task automatic issue(input string name, input logic b, input logic h,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic exp_we, input logic [31:0] exp_data,
                       input logic exp_mis, input int exp_stall, input int exp_lat,
                       input logic scramble);
    wr_t w;
    int  stall_cnt;
    int  lat;
    if (exp_we) begin
      w.addr = a[11:2];
      w.data = exp_data;
      wr_q.push_back(w);
    end
    done_q.push_back(exp_mis);
    Byte = b; Half = h; Addr = a; Wdata = d; Memwrite = 1'b1;
    stall_cnt = 0;
    lat       = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      #1;
      if (Stall === 1'b1) stall_cnt++;
      if (Done === 1'b1)  lat = c;
      @(negedge clk);
      if (scramble && c == 1) begin
        Addr  = ~a;
        Wdata = ~d;
        Byte  = ~b;
      end
    end
    check({name, "_stall_cycles"}, stall_cnt, exp_stall);
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    rst = 1'b1; Memwrite = 1'b1; Byte = 1'b0; Half = 1'b0;
    Addr = 32'h10; Wdata = 32'h1234;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",    {31'b0, Stall},    32'd0);
    check("rst_we",       {31'b0, Mem_we},   32'd0);
    check("rst_done",     {31'b0, Done},     32'd0);
    check("rst_misalign", {31'b0, Misalign}, 32'd0);

    @(negedge clk);
    rst = 1'b0; Memwrite = 1'b0; Addr = 32'h0000_0ABC;
    #1;
    check("idle_stall", {31'b0, Stall},  32'd0);
    check("idle_we",    {31'b0, Mem_we}, 32'd0);
    check("idle_done",  {31'b0, Done},   32'd0);
    check("idle_wdata", Mem_wdata,       32'd0);
    check("idle_addr",  {22'b0, Mem_addr}, 32'h2AF);
    @(negedge clk);

    preload(10'd4, 32'h1122_3344);
    issue("sb_lane3", 1, 0, 32'h13, 32'h0000_00AB, 1, 32'hAB22_3344, 0, 2, 3, 1);
    go_idle();
    issue("sw_aligned", 0, 0, 32'h10, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 1, 2, 0);
    go_idle();
    preload(10'd1, 32'h1122_3344);
    issue("sh_upper", 0, 1, 32'h6, 32'h0000_CAFE, 1, 32'hCAFE_3344, 0, 2, 3, 0);
    go_idle();
    preload(10'd1, 32'h1122_3344);
    issue("sh_lower", 0, 1, 32'h4, 32'h9999_CAFE, 1, 32'h1122_CAFE, 0, 2, 3, 0);
    go_idle();
    issue("sw_misalign", 0, 0, 32'h12, 32'h5555_5555, 0, 32'h0, 1, 1, 2, 0);
    go_idle();
    issue("sh_misalign", 0, 1, 32'h5, 32'h0000_7777, 0, 32'h0, 1, 1, 2, 0);
    go_idle();
    preload(10'd0, 32'h1122_3344);
    issue("sb_byte_half", 1, 1, 32'h1, 32'h0000_0055, 1, 32'h1122_5544, 0, 2, 3, 0);
    go_idle();
    preload(10'd2, 32'hAABB_CCDD);
    issue("sb_lane0", 1, 0, 32'h8, 32'h1234_5677, 1, 32'hAABB_CC77, 0, 2, 3, 0);
    go_idle();

    // Back-to-back: the next instruction appears right after the Done cycle.
    issue("b2b_sw", 0, 0, 32'h1234_5FFC, 32'h0102_0304, 1, 32'h0102_0304, 0, 1, 2, 0);
    issue("b2b_sb", 1, 0, 32'hA, 32'h0000_0099, 1, 32'hAA99_CC77, 0, 2, 3, 0);
    go_idle();

    // Reset while the sb read is in flight aborts the store.
    preload(10'd5, 32'h1122_3344);
    Byte = 1'b1; Half = 1'b0; Addr = 32'h14; Wdata = 32'h0000_00EE; Memwrite = 1'b1;
    #1;
    check("abort_accept_stall", {31'b0, Stall}, 32'd1);
    @(negedge clk);
    #1;
    check("abort_read_stall", {31'b0, Stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rst_stall", {31'b0, Stall},  32'd0);
    check("abort_rst_we",    {31'b0, Mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0; Memwrite = 1'b0; Byte = 1'b0; Addr = 32'h0;
    #1;
    check("abort_after_stall", {31'b0, Stall},    32'd0);
    check("abort_after_we",    {31'b0, Mem_we},   32'd0);
    check("abort_after_done",  {31'b0, Done},     32'd0);
    check("abort_after_mis",   {31'b0, Misalign}, 32'd0);
    check("abort_after_wdata", Mem_wdata,         32'd0);
    check("abort_after_addr",  {22'b0, Mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_ram_kept", mem[5], 32'h1122_3344);
    check("sb_lane0_ram",   mem[2], 32'hAA99_CC77);

    repeat (3) @(negedge clk);
    check("writes_outstanding", wr_q.size(),   32'd0);
    check("dones_outstanding",  done_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port Memwrite  input  1  store request from control unit; level, held until Stall falls.
REQ-004 SHALL have port Byte  input  1  store-byte (sb) size select.
REQ-005 SHALL have port Half  input  1  store-halfword (sh) size select; Byte=Half=0 means word (sw).
REQ-006 SHALL have port Addr  input  32  byte address of the store (ALU Result1).
REQ-007 SHALL have port Wdata  input  32  store data (R2_out); the low byte or halfword is used for sb/sh.
REQ-008 SHALL have port Mem_rdata  input  32  data-RAM read word; synchronous RAM, valid the cycle after Mem_addr is presented.
REQ-009 SHALL have port Mem_addr  output  10  data-RAM word address, Addr[11:2] latched.
REQ-010 SHALL have port Mem_we  output  1  data-RAM write enable, one-cycle pulse.
REQ-011 SHALL have port Mem_wdata  output  32  full word written to the RAM.
REQ-012 SHALL have port Stall  output  1  holds PC/pipeline while the store is in progress.
REQ-013 SHALL have port Done  output  1  one-cycle pulse when the store completes or is rejected.
REQ-014 SHALL have port Misalign  output  1  one-cycle pulse when the store is rejected for misalignment.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, WRITE and ERR.
REQ-016 IDLE, Memwrite=1: SHALL latch Addr, Wdata and size, and SHALL assert Stall combinationally in that same cycle.
REQ-017 Size priority SHALL be Byte over Half over word; Byte=Half=1 SHALL be treated as sb.
REQ-018 Alignment: sw with Addr[1:0]!=0, or sh with Addr[0]=1, SHALL go IDLE->ERR; sb is never misaligned.
REQ-019 ERR SHALL hold for 1 cycle with Misalign=1, Done=1, Stall=0 and Mem_we=0, then return to IDLE; the RAM is never written on this path.
REQ-020 Aligned sw SHALL go IDLE->WRITE: Mem_wdata=Wdata latch, Mem_we=1, Done=1, Stall=0, then IDLE; total latency 2 cycles from request.
REQ-021 Aligned sb/sh SHALL go IDLE->READ->WRITE: READ drives Mem_addr with Stall=1 and Mem_we=0; WRITE merges Mem_rdata with Mem_we=1, Done=1, Stall=0; total latency 3 cycles.
REQ-022 sb merge SHALL be little-endian: lane Addr[1:0]=k receives Wdata[7:0] at bits 8k+7..8k; the other 3 bytes come from Mem_rdata.
REQ-023 sh merge SHALL place Wdata[15:0] at bits 15:0 when Addr[1]=0 and at bits 31:16 when Addr[1]=1; the other half comes from Mem_rdata.
REQ-024 Mem_addr SHALL equal the latched Addr[11:2] in READ and WRITE; in IDLE it SHALL pass Addr[11:2] through.
REQ-025 Because Stall is low in the WRITE/ERR cycle, the CPU advances at that edge; IDLE SHALL NOT re-accept the completed instruction in the following cycle.
REQ-026 Input changes during READ/WRITE SHALL be ignored; only the latched values are used.
REQ-027 Mem_we SHALL be asserted only in WRITE, exactly once per accepted aligned store.
REQ-028 Memwrite=0 in IDLE SHALL keep Stall, Mem_we, Done and Misalign at 0.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and clear all latches to 0 (Mem_wdata=0, latched address 0).
REQ-030 While rst=1, Mem_we, Done, Misalign and Stall SHALL be 0.
REQ-031 rst during READ SHALL abort the store with no RAM write; rst during WRITE SHALL leave any write only as committed by the RAM at that edge, and the unit SHALL be in IDLE after the edge.

Structure
REQ-032 A shared package store_pkg SHALL hold the state encodings (2-bit) and the size constants SZ_WORD=0, SZ_HALF=1, SZ_BYTE=2.
REQ-033 The merge logic SHALL be a combinational sub-module byte_lane_merge with inputs old word, new data, size and Addr[1:0], and the merged word as output.
REQ-034 The FSM, latches and output decode SHALL reside in store_merge_unit.

Verification
REQ-035 sw Addr=0x00000010, Wdata=0xDEADBEEF -> next cycle Mem_we=1, Mem_addr=4, Mem_wdata=0xDEADBEEF, Done=1; Stall high for exactly 1 cycle.
REQ-036 sb Addr=0x00000013, Wdata=0x000000AB, RAM word=0x11223344 -> cycle 3 Mem_wdata=0xAB223344, Mem_we=1; Stall high for 2 cycles.
REQ-037 sh Addr=0x00000006, Wdata=0x0000CAFE, RAM word=0x11223344 -> Mem_wdata=0xCAFE3344; sh at 0x4 -> 0x1122CAFE.
REQ-038 sw Addr=0x00000012 -> next cycle Misalign=1, Done=1, Mem_we never asserted; sh at 0x5 gives the same result.
REQ-039 sb accepted, rst=1 in READ cycle -> Mem_we stays 0, state IDLE, all outputs 0 next cycle.
REQ-040 Byte=Half=1 at Addr 0x1 -> treated as sb (lane 1 replaced), no Misalign; back-to-back sw, sb -> each completes with exactly one Mem_we pulse.
